// File: rtl/serial_adder8b.sv
// serial_adder8b
//   Bit-serial 8-bit adder: S = A + B + Cin computed one bit per clock using a
//   single full-adder cell and a carry flip-flop. Trades latency (8 cycles)
//   for area. With B pre-inverted and Cin = 1 it computes A - B, where
//   Cout = 1 means no borrow.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; aborts any operation in flight
//   start  in   request, honoured only in IDLE or DONE
//   A, B   in   8-bit operands, captured when start is accepted
//   Cin    in   carry-in, captured when start is accepted
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when S/Cout/V hold a fresh result
//   S      out  8-bit sum (modulo 256), held until the next completion
//   Cout   out  carry out of bit 7
//   V      out  signed overflow (carry into bit 7 XOR carry out of bit 7)
module serial_adder8b (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic       busy,
  output logic       done,
  output logic [7:0] S,
  output logic       Cout,
  output logic       V
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [7:0] a_sr;
  logic [7:0] b_sr;
  logic [7:0] res_sr;
  logic       carry;
  logic [2:0] cnt;

  logic [1:0] fa_out;
  logic       sum_bit;
  logic       carry_out;
  logic       accept;
  logic       last_bit;

  // Single full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign fa_out    = full_add(a_sr[0], b_sr[0], carry);
  assign sum_bit   = fa_out[0];
  assign carry_out = fa_out[1];

  // A new request is only taken when no operation is in flight; DONE also
  // accepts so back-to-back operations cost no idle cycle.
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == 3'd7);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= 8'h00;
      b_sr   <= 8'h00;
      res_sr <= 8'h00;
      carry  <= 1'b0;
      cnt    <= 3'd0;
      S      <= 8'h00;
      Cout   <= 1'b0;
      V      <= 1'b0;
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B;
      carry <= Cin;
      cnt   <= 3'd0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= carry_out;
      res_sr <= {sum_bit, res_sr[7:1]};
      cnt    <= cnt + 3'd1;
      // Publish the whole word at once so partial sums never reach S.
      if (last_bit) begin
        S    <= {sum_bit, res_sr[7:1]};
        Cout <= carry_out;
        V    <= carry ^ carry_out;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder8b.sv
module tb_serial_adder8b;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       busy;
  logic       done;
  logic [7:0] S;
  logic       Cout;
  logic       V;

  int nvec;
  int nerr;

  serial_adder8b dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .V     (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation with a single-cycle start pulse and wait (bounded)
  // for done. lat counts cycles from the first busy cycle to done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [7:0] s, output logic co, output logic v,
                        output int lat, output int nbusy, output bit ok);
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; nbusy = 0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nbusy++;
      lat++;
      @(negedge clk);
    end
    s = S; co = Cout; v = V;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({busy, done, S, Cout, V} !== 12'h000) begin
      nerr++;
      $display("FAIL reset_state: busy=%b done=%b S=%h Cout=%b V=%b, want all 0", busy, done, S, Cout, V);
    end
    // start coincident with reset must be dropped
    start = 1'b1; A = 8'hAA; B = 8'h55;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_start_drop: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] s; logic co, v; int lat, nb; bit ok;
    run_op(8'h3C, 8'h15, 1'b0, s, co, v, lat, nb, ok);
    nvec++;
    if (!ok || lat != 8) begin
      nerr++;
      $display("FAIL basic_latency: done_seen=%0d latency=%0d, want 1 and 8", ok, lat);
    end
    nvec++;
    if (nb != 8) begin
      nerr++;
      $display("FAIL basic_busy_cycles: %0d, want 8", nb);
    end
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL basic_busy_in_done: busy=%b, want 0", busy);
    end
    nvec++;
    if ({s, co, v} !== {8'h51, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL basic_result: S=%h Cout=%b V=%b, want 51 0 0", s, co, v);
    end
    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0 || S !== 8'h51) begin
      nerr++;
      $display("FAIL basic_pulse_hold: done=%b busy=%b S=%h, want 0 0 51", done, busy, S);
    end
  endtask

  task automatic test_carry_overflow();
    logic [7:0] s; logic co, v; int lat, nb; bit ok;
    run_op(8'hFF, 8'h01, 1'b0, s, co, v, lat, nb, ok);
    nvec++;
    if (!ok || {s, co, v} !== {8'h00, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL carry_ff_01: ok=%0d S=%h Cout=%b V=%b, want 00 1 0", ok, s, co, v);
    end
    run_op(8'h7F, 8'h01, 1'b0, s, co, v, lat, nb, ok);
    nvec++;
    if (!ok || {s, co, v} !== {8'h80, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL overflow_7f_01: ok=%0d S=%h Cout=%b V=%b, want 80 0 1", ok, s, co, v);
    end
  endtask

  task automatic test_subtract();
    logic [7:0] s; logic co, v; int lat, nb; bit ok;
    run_op(8'h5A, 8'hC3, 1'b1, s, co, v, lat, nb, ok);
    nvec++;
    if (!ok || {s, co, v} !== {8'h1E, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL sub_no_borrow: ok=%0d S=%h Cout=%b V=%b, want 1e 1 0", ok, s, co, v);
    end
    run_op(8'h10, 8'hDF, 1'b1, s, co, v, lat, nb, ok);
    nvec++;
    if (!ok || {s, co, v} !== {8'hF0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL sub_borrow: ok=%0d S=%h Cout=%b V=%b, want f0 0 0", ok, s, co, v);
    end
  endtask

  task automatic test_back_to_back();
    int ndone; int t1, t2; logic [7:0] s1, s2; logic c2; bit busy_at_done;
    ndone = 0; t1 = 0; t2 = 0; s1 = 8'h00; s2 = 8'h00; c2 = 1'b0; busy_at_done = 1'b0;
    @(negedge clk);
    A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (busy) busy_at_done = 1'b1;
        if (ndone == 1) begin t1 = i; s1 = S; end
        if (ndone == 2) begin t2 = i; s2 = S; c2 = Cout; end
      end
      if (done && ndone == 1) begin
        A = 8'h01; B = 8'h02; Cin = 1'b1;
      end else begin
        if (ndone >= 1) start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
      end
    end
    start = 1'b0;
    nvec++;
    if (ndone != 2) begin
      nerr++;
      $display("FAIL b2b_done_count: %0d, want 2", ndone);
    end
    nvec++;
    if (t1 != 9 || t2 != 18) begin
      nerr++;
      $display("FAIL b2b_timing: first=%0d second=%0d, want 9 and 18", t1, t2);
    end
    nvec++;
    if (s1 !== 8'h46 || s2 !== 8'h04 || c2 !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_results: S1=%h S2=%h Cout2=%b, want 46 04 0", s1, s2, c2);
    end
    nvec++;
    if (busy_at_done) begin
      nerr++;
      $display("FAIL b2b_busy_in_done: busy seen 1 with done, want 0");
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] s; logic co, v; int lat, nb; bit ok; int ndone;
    run_op(8'hF0, 8'h0F, 1'b0, s, co, v, lat, nb, ok);
    @(negedge clk);
    A = 8'h11; B = 8'h22; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nvec++;
    if ({busy, done, S, Cout, V} !== 12'h000) begin
      nerr++;
      $display("FAIL abort_state: busy=%b done=%b S=%h Cout=%b V=%b, want all 0", busy, done, S, Cout, V);
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    nvec++;
    if (ndone != 0) begin
      nerr++;
      $display("FAIL abort_no_done: %0d active cycles, want 0", ndone);
    end
    run_op(8'h80, 8'h80, 1'b0, s, co, v, lat, nb, ok);
    nvec++;
    if (!ok || {s, co, v} !== {8'h00, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL abort_then_80_80: ok=%0d S=%h Cout=%b V=%b, want 00 1 1", ok, s, co, v);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, s, es; logic cin, co, v, ec, ev; logic [8:0] sum9;
    int lat, nb; bit ok;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      sum9 = {1'b0, a} + {1'b0, b} + {8'h00, cin};
      es = sum9[7:0];
      ec = sum9[8];
      ev = (a[7] == b[7]) && (es[7] != a[7]);
      run_op(a, b, cin, s, co, v, lat, nb, ok);
      nvec++;
      if (!ok || lat != 8 || {s, co, v} !== {es, ec, ev}) begin
        nerr++;
        $display("FAIL random %h+%h+%b: ok=%0d lat=%0d S=%h Cout=%b V=%b, want %h %b %b",
                 a, b, cin, ok, lat, s, co, v, es, ec, ev);
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_basic();
    test_carry_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_adder8b.md
# serial_adder8b

Bit-serial 8-bit adder with a start/done handshake: it computes S = A + B + Cin over eight clock cycles using a single full-adder cell and a carry flip-flop. It is the addition-side counterpart of the combinational subtractor in the arithmetic library. It serves datapaths that trade latency for area. With B pre-inverted and Cin = 1, it also performs A − B, and then Cout = 1 means no borrow.

## Interface
Parameters: none (width fixed at 8).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE or DONE
- A  in  8  augend, captured on accepted start
- B  in  8  addend, captured on accepted start
- Cin  in  1  carry-in, captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; S/Cout/V valid
- S  out  8  sum, registered, holds until next completion
- Cout  out  1  carry out of bit 7, registered
- V  out  1  signed overflow = carry-into-bit-7 XOR Cout, registered

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE with bit counter = 0 and carry FF = 0. Reset also clears busy, done, S, Cout and V to 0 and clears the operand shift registers.
- IDLE, start=1: capture A and B into right-shift registers and Cin into the carry FF, set counter = 0, go to RUN. With start=0, stay in IDLE.
- RUN: each cycle, the full adder takes the LSB of each operand register and the carry FF.
  - The sum bit shifts into the MSB of a result shift register.
  - The carry FF takes the new carry. Both operand registers shift right by 1. The counter increments.
  - On the cycle where counter = 7:
    - copy the complete result to S.
    - copy the adder's carry out to Cout.
    - set V = (carry FF before this bit) XOR (carry out).
    - go to DONE.
- start during RUN is ignored. No queuing takes place, and A, B and Cin changes have no effect.
- DONE lasts one cycle with done=1.
  - If start=1 in DONE, capture new operands and go directly to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- S, Cout and V change only at the completion edge or on reset. Intermediate sums are never visible on S.
- Width rule: the result is modulo 2^8, and the ninth bit appears only on Cout.

## Timing
- Start accepted at edge k: busy=1 from after edge k through edge k+8.
- Bits 0..7 are processed at edges k+1..k+8.
- S, Cout and V update at edge k+8. done=1 for the cycle after edge k+8, and busy=0 in that cycle.
- Latency from start edge to done is 8 cycles. Throughput is one result per 9 cycles with back-to-back starts.
- Reset takes priority over all events, including in RUN. At the next edge the block is in IDLE with outputs at 0, and the aborted operation produces no done.
- If start and reset are asserted at the same edge, the start is discarded.

## Test plan
- Reset, then A=0x3C, B=0x15, Cin=0 with start for 1 cycle → done 8 cycles after the start edge; S=0x51, Cout=0, V=0; busy high for exactly 8 cycles.
- A=0xFF, B=0x01, Cin=0 → S=0x00, Cout=1, V=0. Then A=0x7F, B=0x01 → S=0x80, Cout=0, V=1.
- Subtract mode: A=0x5A, B=0xC3 (~0x3C), Cin=1 → S=0x1E, Cout=1 (no borrow). A=0x10, B=0xDF (~0x20), Cin=1 → S=0xF0, Cout=0 (borrow).
- Hold start=1 and toggle A/B during RUN → exactly one done; result equals the operands captured at acceptance. With start still high in DONE → a second operation begins immediately, and its done follows 9 cycles after the first.
- Assert reset at the 4th RUN cycle → next cycle IDLE with busy=0, S=0x00, Cout=0, V=0, and no done pulse. A subsequent 0x80+0x80 → S=0x00, Cout=1, V=1.
- Random sweep of ≥1000 (A, B, Cin) triples vs. a reference model {Cout,S} = A+B+Cin, with V checked as signed overflow.
